// File: rtl/nibble_pack16_pkg.sv
// Shared constants and types for the nibble packer: word geometry, FSM states
// and the bundle carried by the output register.
package nibble_pack_pkg;
   localparam int WIDTH_IN = 4;
   localparam int NIBBLES  = 4;
   localparam int OUT_W    = WIDTH_IN * NIBBLES;
   localparam int CNT_W    = $clog2(NIBBLES) + 1;
   localparam int IDX_W    = $clog2(NIBBLES);

   typedef enum logic [0:0] {
      EMPTY   = 1'b0,
      PARTIAL = 1'b1
   } fsm_e;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [CNT_W-1:0] count;
      logic             last;
   } out_word_t;
endpackage

// File: rtl/nibble_pack16_if.sv
// Nibble-in / word-out stream bundle. The design takes the slave side and the
// feeder/sink takes the master side.
interface nibble_pack16_if;
   logic                               in_valid;
   logic                               in_ready;
   logic [nibble_pack_pkg::WIDTH_IN-1:0] in_data;
   logic                               in_last;
   logic                               out_valid;
   logic                               out_ready;
   logic [nibble_pack_pkg::OUT_W-1:0]  out_data;
   logic [nibble_pack_pkg::CNT_W-1:0]  out_count;
   logic                               out_last;
   logic [15:0]                        word_cnt;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_last, word_cnt
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_last, word_cnt
   );
endinterface

// File: rtl/nibble_pack16_pack_out_reg.sv
// Single-entry valid/ready output register. Reloading while draining keeps
// out_valid high, so back-to-back words flow without a bubble.
module pack_out_reg
   import nibble_pack_pkg::*;
(
   input  logic      clk,
   input  logic      arst,
   input  logic      load,
   input  out_word_t load_word,
   input  logic      out_ready,
   output logic      out_valid,
   output out_word_t out_word,
   output logic      in_ready,
   output logic      handoff
);

   assign handoff  = out_valid && out_ready;
   // Upstream may only load when the slot is free or draining this cycle.
   assign in_ready = !arst && (!out_valid || out_ready);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         out_valid <= 1'b0;
         out_word  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_word  <= load_word;
      end else if (handoff) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nibble_pack16.sv
// Packs a valid/ready nibble stream little-endian into 16-bit words, with
// early flush on in_last (upper nibbles zero) and a handoff counter.
module nibble_pack16
   import nibble_pack_pkg::*;
(
   input  logic            clk,
   input  logic            arst,
   nibble_pack16_if.slave  bus
);

   localparam logic [0:0] S_EMPTY   = EMPTY;
   localparam logic [0:0] S_PARTIAL = PARTIAL;

   logic [0:0]                       state;
   logic [IDX_W-1:0]                 idx;
   logic [NIBBLES-1:0][WIDTH_IN-1:0] acc;
   logic [NIBBLES-1:0][WIDTH_IN-1:0] merged;
   logic                             accept;
   logic                             complete;
   logic                             handoff;
   logic                             in_ready;
   logic                             out_valid;
   out_word_t                        load_word;
   out_word_t                        out_word;
   logic [15:0]                      wcnt;

   assign accept   = bus.in_valid && in_ready;
   assign complete = accept && ((idx == IDX_W'(NIBBLES-1)) || bus.in_last);

   // Slots above idx are zero in the accumulator, which gives the flush padding.
   for (genvar i = 0; i < NIBBLES; i++) begin : g_merge
      assign merged[i] = (idx == IDX_W'(i))   ? bus.in_data :
                         (state == S_EMPTY)   ? '0          : acc[i];
   end

   assign load_word.data  = merged;
   assign load_word.count = CNT_W'(idx) + CNT_W'(1);
   assign load_word.last  = bus.in_last;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         acc   <= '0;
         idx   <= '0;
         state <= S_EMPTY;
      end else if (complete) begin
         acc   <= '0;
         idx   <= '0;
         state <= S_EMPTY;
      end else if (accept) begin
         acc   <= merged;
         idx   <= idx + IDX_W'(1);
         state <= S_PARTIAL;
      end
   end

   pack_out_reg u_out (
      .clk       (clk),
      .arst      (arst),
      .load      (complete),
      .load_word (load_word),
      .out_ready (bus.out_ready),
      .out_valid (out_valid),
      .out_word  (out_word),
      .in_ready  (in_ready),
      .handoff   (handoff)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst)         wcnt <= '0;
      else if (handoff) wcnt <= wcnt + 16'd1;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_word.data;
   assign bus.out_count = out_word.count;
   assign bus.out_last  = out_word.last;
   assign bus.word_cnt  = wcnt;

endmodule

// File: tb/tb_nibble_pack16.sv
// Randomized bench for nibble_pack16 against a queue-based packet model.
module tb_nibble_pack16;
   import nibble_pack_pkg::*;

   logic clk = 1'b0;
   logic arst;

   nibble_pack16_if bus();

   nibble_pack16 dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: nibbles of the open packet, words awaiting handoff, handoff count.
   logic [3:0]  pkt[$];
   logic [19:0] expq[$];
   logic [15:0] wc;
   logic [37:0] got_t, exp_t;

   task automatic model_clear();
      pkt.delete();
      expq.delete();
      wc = '0;
   endtask

   // Drive one cycle, sample observed/expected before the edge, advance model.
   task automatic step(input logic v, input logic [3:0] d, input logic l, input logic ordy);
      logic        pend, acc, ho;
      logic [15:0] w;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = ordy;
      #1;
      pend  = expq.size() != 0;
      exp_t = {pend, !pend || ordy, wc, pend ? expq[0] : 20'h0};
      got_t = {bus.out_valid, bus.in_ready, bus.word_cnt,
               bus.out_valid ? {bus.out_data, bus.out_count, bus.out_last} : 20'h0};
      ho  = pend && ordy;
      acc = v && (!pend || ordy);
      if (ho) begin
         void'(expq.pop_front());
         wc = wc + 16'd1;
      end
      if (acc) begin
         pkt.push_back(d);
         if (pkt.size() == NIBBLES || l) begin
            w = '0;
            foreach (pkt[i]) w = w | (16'(pkt[i]) << (4 * i));
            expq.push_back({w, 3'(pkt.size()), l});
            pkt.delete();
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.in_valid = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      arst          = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      #2;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_last, bus.word_cnt} !== 38'h0) begin
         errors++;
         $display("FAIL reset_state: got v=%b rdy=%b data=%h cnt=%0d last=%b wc=%h want all zero",
                  bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_last, bus.word_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst = 1'b0;
      model_clear();
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) step(1'b1, 4'(i + 1), 1'b0, 1'b1);
         else       step(1'b0, 4'h0, 1'b0, 1'b1);
         checks++;
         if (got_t !== exp_t) begin
            errors++;
            $display("FAIL basic cyc%0d: got %h want %h", i, got_t, exp_t);
         end
         if (i == 4) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_count, bus.out_last} !== {1'b1, 16'h4321, 3'd4, 1'b0}) begin
               errors++;
               $display("FAIL basic_word: got v=%b %h cnt=%0d last=%b want 1 4321 4 0",
                        bus.out_valid, bus.out_data, bus.out_count, bus.out_last);
            end
         end
      end
      checks++;
      if (bus.word_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic_word_cnt: got %0d want 1", bus.word_cnt);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         if (i < 8) step(1'b1, 4'(i), 1'b0, 1'b1);
         else       step(1'b0, 4'h0, 1'b0, 1'b1);
         checks++;
         if (got_t !== exp_t) begin
            errors++;
            $display("FAIL back_to_back cyc%0d: got %h want %h", i, got_t, exp_t);
         end
      end
   endtask

   task automatic test_short();
      logic [3:0] nib [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      for (int i = 0; i < 8; i++) begin
         if (i < 6) step(1'b1, nib[i], (i == 1), 1'b1);
         else       step(1'b0, 4'h0, 1'b0, 1'b1);
         checks++;
         if (got_t !== exp_t) begin
            errors++;
            $display("FAIL short cyc%0d: got %h want %h", i, got_t, exp_t);
         end
         if (i == 2) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_count, bus.out_last} !== {1'b1, 16'h00BA, 3'd2, 1'b1}) begin
               errors++;
               $display("FAIL short_word: got v=%b %h cnt=%0d last=%b want 1 00ba 2 1",
                        bus.out_valid, bus.out_data, bus.out_count, bus.out_last);
            end
         end
         if (i == 6) begin
            checks++;
            if (bus.out_data[3:0] !== 4'hC) begin
               errors++;
               $display("FAIL short_next_first: got %h want c", bus.out_data[3:0]);
            end
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 12; i++) begin
         if (i < 4)       step(1'b1, 4'(9 - i), 1'b0, 1'b1);
         else if (i < 9)  step(1'b1, 4'($urandom), 1'b0, 1'b0);
         else if (i == 9) step(1'b1, 4'h1, 1'b0, 1'b1);
         else             step(1'b0, 4'h0, 1'b0, 1'b1);
         checks++;
         if (got_t !== exp_t) begin
            errors++;
            $display("FAIL stall cyc%0d: got %h want %h", i, got_t, exp_t);
         end
      end
      step(1'b1, 4'h2, 1'b1, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'h1, 1'b0, 1'b1);
      step(1'b1, 4'h2, 1'b0, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 arst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_last, bus.word_cnt} !== 38'h0) begin
         errors++;
         $display("FAIL reset_mid_partial: got v=%b rdy=%b data=%h wc=%h want all zero",
                  bus.out_valid, bus.in_ready, bus.out_data, bus.word_cnt);
      end
      @(negedge clk);
      arst = 1'b0;
      model_clear();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) step(1'b1, 4'(i + 5), 1'b0, 1'b0);
         else       step(1'b0, 4'h0, 1'b0, 1'b0);
         checks++;
         if (got_t !== exp_t) begin
            errors++;
            $display("FAIL reset_mid cyc%0d: got %h want %h", i, got_t, exp_t);
         end
      end
      checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h8765}) begin
         errors++;
         $display("FAIL reset_mid_word: got v=%b %h want 1 8765", bus.out_valid, bus.out_data);
      end
      #2 arst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_last, bus.word_cnt} !== 38'h0) begin
         errors++;
         $display("FAIL reset_mid_pending: got v=%b rdy=%b data=%h cnt=%0d last=%b want all zero",
                  bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_last);
      end
      @(negedge clk);
      arst = 1'b0;
      model_clear();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 2) != 0));
         checks++;
         if (got_t !== exp_t) begin
            errors++;
            $display("FAIL random cyc%0d: got %h want %h", i, got_t, exp_t);
         end
      end
      step(1'b1, 4'h3, 1'b1, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      logic hit = 1'b0;
      do_reset();
      for (int n = 0; n < 70000 && !hit; n++) begin
         step(1'b1, 4'($urandom), 1'b1, 1'b1);
         if (exp_t[35:20] == 16'hFFFF) begin
            hit = 1'b1;
            checks++;
            if (got_t !== exp_t) begin
               errors++;
               $display("FAIL wrap_preload: got %h want %h", got_t, exp_t);
            end
         end
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wrap_timeout: word_cnt got %h want ffff within bound", bus.word_cnt);
      end
      step(1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (bus.word_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_zero: got %h want 0000", bus.word_cnt);
      end
      checks++;
      if (got_t !== exp_t) begin
         errors++;
         $display("FAIL wrap_after: got %h want %h", got_t, exp_t);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_short();
      test_stall();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nibble_pack16.md
Name: nibble_pack16

Overview:
- Upstream feeder for the 16-bit nibble-rotate concat/slice datapath.
- Accepts a stream of 4-bit nibbles under valid/ready and packs them little-endian into 16-bit words; the first nibble lands in bits [3:0].
- A short packet can be flushed early with in_last; unused upper nibbles are zero-padded.
- One registered output stage provides full throughput, one nibble per cycle.

Parameters:
- WIDTH_IN, 4: nibble width in bits.
- NIBBLES, 4: nibbles per output word. Output width OUT_W = WIDTH_IN*NIBBLES (16).
- CNT_W, $clog2(NIBBLES)+1 (3): width of out_count.

Ports:
- clk, input, 1: rising-edge clock.
- arst, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: nibble present.
- in_ready, output, 1: block can accept a nibble this cycle.
- in_data, input, WIDTH_IN: nibble.
- in_last, input, 1: this nibble ends the packet; flush the partial word.
- out_valid, output, 1: packed word present.
- out_ready, input, 1: downstream accepts the word.
- out_data, output, OUT_W: packed word.
- out_count, output, CNT_W: number of real nibbles in out_data, 1..NIBBLES.
- out_last, output, 1: word ends a packet.
- word_cnt, output, 16: count of words handed off downstream; wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock, clk. Reset arst is asynchronous and active-high.
- Reset values: all state and outputs clear asynchronously. out_valid=0, out_data=0, out_count=0, out_last=0, word_cnt=0, accumulator=0, idx=0, FSM=EMPTY. in_ready is forced to 0 while arst is high.
- Handshake:
  - A nibble is accepted when in_valid && in_ready.
  - A word is handed off when out_valid && out_ready.
  - in_ready = !arst && (!out_valid || out_ready). This is registered-state-only logic plus out_ready, with no dependence on in_valid, in_data or in_last.
- FSM states:
  - EMPTY: idx==0, no partial data.
  - PARTIAL: 1..NIBBLES-1 nibbles held.
- On accept:
  - The nibble is written to accumulator bits [idx*WIDTH_IN +: WIDTH_IN].
  - If idx==NIBBLES-1 or in_last, the word completes. It is loaded into the output register as {zero pad, accumulator with the new nibble merged}. out_count=idx+1, out_last=in_last, out_valid=1.
  - On completion the accumulator clears, idx goes to 0 and the FSM goes to EMPTY.
  - Otherwise idx increments and the FSM goes to PARTIAL.
- Latency: out_valid rises the cycle after the completing nibble is accepted.
- Output register:
  - Holds stable while out_valid && !out_ready.
  - Handoff without a new completion clears out_valid. out_data, out_count and out_last keep their last values.
  - Handoff and completion in the same cycle reload the register with out_valid staying 1. No bubble.
- word_cnt increments by 1 on every handoff and wraps from 0xFFFF to 0x0000.
- Stall: while in_ready=0, the accumulator, idx and FSM hold, including mid-word.
- in_last in EMPTY: produces a 1-nibble word with out_count=1.
- in_last with idx==NIBBLES-1: normal full word with out_last=1 and out_count=NIBBLES.
- in_valid=0: no state change except the output handoff.
- Reset mid-packet: the partial word and any pending output word are discarded. The first nibble after reset is again nibble 0.

Decomposition:
- Package nibble_pack_pkg:
  - Constants WIDTH_IN, NIBBLES, OUT_W, CNT_W.
  - FSM enum {EMPTY, PARTIAL}.
  - Output bundle typedef {data[OUT_W], count[CNT_W], last}.
- One sub-module, pack_out_reg: a single-entry valid/ready register slice.
  - Async active-high reset.
  - Load/hold/drain rules as above.
  - Generates in_ready and the word_cnt increment strobe.
- Accumulator, idx and FSM stay in the top module.

Test Plan:
- Reset then 4 nibbles 0x1,0x2,0x3,0x4 back-to-back, out_ready=1 -> one cycle after the 4th accept: out_data=0x4321, out_count=4, out_last=0, word_cnt becomes 1 on the handoff.
- 8 nibbles 0x0..0x7 continuous, out_ready=1 -> words 0x3210 then 0x7654 on consecutive handoffs, in_ready never drops, no bubble.
- Nibbles 0xA,0xB with in_last on 0xB -> out_data=0x00BA, out_count=2, out_last=1; next packet nibble 0xC lands in bits [3:0].
- Completed word with out_ready=0 for 5 cycles -> out_valid/out_data held constant, in_ready=0, in_valid nibbles not accepted; out_ready=1 -> handoff, in_ready=1 the same cycle.
- Assert arst for one cycle after 2 nibbles with an output word pending -> all outputs 0 immediately (async, mid-cycle); next 4 nibbles 0x5,0x6,0x7,0x8 -> 0x8765.
- Preload word_cnt to 0xFFFF via 65535 single-nibble in_last packets -> next handoff wraps word_cnt to 0x0000.
